// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST controller with a solid data background.
//   M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 up(r0)
// One memory op per cycle while running. Read data returns two cycles after the
// read is issued and is compared against the expected solid word.
//
// Parameters:
//   DATA_WIDTH  memory word width
//   ADDR_WIDTH  memory address width
//   ADDR_MAX    highest tested address (lowest is 0)
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle request to begin a test (ignored while busy)
//   write_read  memory op: 1 = write, 0 = read
//   address     memory address
//   wdata       write data, presented one cycle ahead of its write
//   rdata       memory read data (two-cycle read latency)
//   busy        test in progress (RUN or DRAIN)
//   done        test complete, held until the next accepted start
//   fail        sticky: at least one read mismatch
//   fail_count  saturating mismatch count
//   fail_addr   address of the first mismatch
//   fail_data   read data of the first mismatch
// Configuration:
//   MBIST_FAIL_LOG_EN  when defined, implements fail_count/fail_addr/fail_data;
//                      otherwise those outputs are tied to 0.

module mbist_march_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned ADDR_MAX   = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [7:0]            fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
);

    localparam int unsigned ELEM_W = 3;
    localparam int unsigned CNT_W  = 8;
    localparam logic [ADDR_WIDTH-1:0] A_MAX = ADDR_WIDTH'(ADDR_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ELEM_W-1:0]   elem_q, elem_d;
    logic                drain_q, drain_d;
    logic                wr_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                busy_d, done_d, fail_d;

    // Compare pipeline; the expected word is solid, so one bit encodes it.
    logic                p1_vld, p1_exp, p2_vld, p2_exp;
    logic                p1_vld_d, p1_exp_d, p2_vld_d, p2_exp_d;

    logic                start_acc_c;
    logic                mismatch_c;
    logic                elem_down_c;
    logic [ADDR_WIDTH-1:0] elem_last_c;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            elem_q     <= '0;
            drain_q    <= 1'b0;
            write_read <= 1'b0;
            address    <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            p1_vld     <= 1'b0;
            p1_exp     <= 1'b0;
            p2_vld     <= 1'b0;
            p2_exp     <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            drain_q    <= drain_d;
            write_read <= wr_d;
            address    <= addr_d;
            wdata      <= wdata_d;
            busy       <= busy_d;
            done       <= done_d;
            fail       <= fail_d;
            p1_vld     <= p1_vld_d;
            p1_exp     <= p1_exp_d;
            p2_vld     <= p2_vld_d;
            p2_exp     <= p2_exp_d;
        end
    end

    // Next-state, march sequencing and compare
    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        drain_d  = drain_q;
        wr_d     = 1'b0;
        addr_d   = address;
        done_d   = done;

        start_acc_c = start && ((state_q == IDLE) || (state_q == DONE));

        // M3 and M4 walk downward; every other element walks upward.
        elem_down_c = (elem_q == ELEM_W'(3)) || (elem_q == ELEM_W'(4));
        elem_last_c = elem_down_c ? '0 : A_MAX;

        // Stage 1 captures the op issued this cycle if it is a read.
        p1_vld_d = (state_q == RUN) && !write_read;
        p1_exp_d = (elem_q == ELEM_W'(2)) || (elem_q == ELEM_W'(4));
        p2_vld_d = p1_vld;
        p2_exp_d = p1_exp;

        mismatch_c = p2_vld && (rdata != {DATA_WIDTH{p2_exp}});
        fail_d     = fail || mismatch_c;

        case (state_q)
            IDLE, DONE: begin
                addr_d = '0;
                if (start_acc_c) begin
                    state_d = RUN;
                    elem_d  = '0;
                    addr_d  = '0;
                    wr_d    = 1'b1;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            RUN: begin
                if (elem_q == ELEM_W'(0)) begin
                    // M0: writes only
                    if (address == A_MAX) begin
                        elem_d = ELEM_W'(1);
                        addr_d = '0;
                        wr_d   = 1'b0;
                    end else begin
                        addr_d = address + ADDR_WIDTH'(1);
                        wr_d   = 1'b1;
                    end
                end else if (elem_q == ELEM_W'(5)) begin
                    // M5: reads only, last element
                    if (address == A_MAX) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                        addr_d  = '0;
                    end else begin
                        addr_d = address + ADDR_WIDTH'(1);
                    end
                end else if (!write_read) begin
                    // Read of a cell is always followed by its write.
                    wr_d   = 1'b1;
                    addr_d = address;
                end else if (address == elem_last_c) begin
                    elem_d = elem_q + ELEM_W'(1);
                    // Entering M3 or M4 starts at the top address.
                    addr_d = ((elem_q == ELEM_W'(2)) || (elem_q == ELEM_W'(3))) ? A_MAX : '0;
                    wr_d   = 1'b0;
                end else begin
                    addr_d = elem_down_c ? (address - ADDR_WIDTH'(1))
                                         : (address + ADDR_WIDTH'(1));
                    wr_d   = 1'b0;
                end
            end
            DRAIN: begin
                addr_d = '0;
                // Two cycles lets the final M5 read reach the comparator.
                if (drain_q) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);

        // Each element has one write value, so holding it for the whole element
        // keeps wdata one cycle ahead of every write; 0 outside RUN covers M0.
        if (state_d == RUN) begin
            wdata_d = {DATA_WIDTH{(elem_d == ELEM_W'(1)) || (elem_d == ELEM_W'(3))}};
        end else begin
            wdata_d = '0;
        end
    end

`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] p1_addr, p2_addr;

    // Failure log: count every mismatch, capture details of the first one.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_addr    <= '0;
            p2_addr    <= '0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else begin
            p1_addr <= address;
            p2_addr <= p1_addr;
            if (start_acc_c) begin
                fail_count <= '0;
                fail_addr  <= '0;
                fail_data  <= '0;
            end else if (mismatch_c) begin
                if (fail_count != {CNT_W{1'b1}}) begin
                    fail_count <= fail_count + CNT_W'(1);
                end
                if (!fail) begin
                    fail_addr <= p2_addr;
                    fail_data <= rdata;
                end
            end
        end
    end
`else
    assign fail_count = '0;
    assign fail_addr  = '0;
    assign fail_data  = '0;
`endif

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-003 SHALL have parameter ADDR_MAX, default 2**ADDR_WIDTH-1, highest tested address (lowest is 0).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a test.
REQ-007 SHALL have port write_read, output, 1, memory op: 1 = write, 0 = read.
REQ-008 SHALL have port address, output, ADDR_WIDTH, memory address.
REQ-009 SHALL have port wdata, output, DATA_WIDTH, memory write data.
REQ-010 SHALL have port rdata, input, DATA_WIDTH, memory read data.
REQ-011 SHALL have port busy, output, 1, test in progress.
REQ-012 SHALL have port done, output, 1, test complete; level, held until the next accepted start.
REQ-013 SHALL have port fail, output, 1, sticky: at least one read mismatch.
REQ-014 SHALL have port fail_count, output, 8, saturating mismatch count.
REQ-015 SHALL have port fail_addr, output, ADDR_WIDTH, address of the first mismatch.
REQ-016 SHALL have port fail_data, output, DATA_WIDTH, read data of the first mismatch.

Function
REQ-017 SHALL run March C- with solid background: M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 up(r0); 0 = all-zeros word, 1 = all-ones word.
REQ-018 SHALL use states IDLE, RUN, DRAIN, DONE; IDLE/DONE + start -> RUN; RUN after the last M5 op -> DRAIN; DRAIN after 2 cycles -> DONE.
REQ-019 SHALL issue exactly one memory op per cycle in RUN: 10*(ADDR_MAX+1) ops, no bubbles.
REQ-020 SHALL, within a cell, issue the read and then the write to the same address on consecutive cycles.
REQ-021 SHALL step up-elements from 0 to ADDR_MAX and down-elements from ADDR_MAX to 0, with no address wrap.
REQ-022 SHALL drive wdata one cycle ahead of its write: the wdata value at cycle c is the data for the write issued at cycle c+1, including the first write of M0.
REQ-023 SHALL drive write_read=0 outside RUN.
REQ-024 SHALL compare rdata against the expected word 2 cycles after each read issue, via a 2-stage pipeline carrying {valid, expected, address}.
REQ-025 SHALL compare the last M5 read during DRAIN, before done rises.
REQ-026 SHALL, on each mismatch, set fail and increment fail_count (saturating at 255).
REQ-027 SHALL capture fail_addr and fail_data on the first mismatch only.
REQ-028 SHALL, when start is accepted, clear fail, fail_count, fail_addr, fail_data and done.
REQ-029 SHALL raise busy on the cycle after start is accepted; busy SHALL be high in RUN and DRAIN.
REQ-030 SHALL ignore start while busy=1.

Reset
REQ-031 SHALL, with rst=1 at a clock edge, go to IDLE and drive busy, done, fail, write_read, address, wdata, fail_count, fail_addr and fail_data to 0, and clear the compare pipeline.
REQ-032 SHALL abort a test that is in progress when rst is asserted, with no done pulse and no compare issued afterwards.
REQ-033 SHALL give rst priority over a simultaneous start.

Configuration
REQ-034 SHALL, with MBIST_FAIL_LOG_EN defined, implement fail_count, fail_addr and fail_data as specified.
REQ-035 SHALL, without MBIST_FAIL_LOG_EN, tie fail_count, fail_addr and fail_data to 0, omit their registers, and keep fail and done behaviour unchanged.

Verification
REQ-036 SHALL cover: fault-free memory, DATA_WIDTH=8, ADDR_WIDTH=4, one start pulse -> busy for 162 cycles, done=1, fail=0, fail_count=0.
REQ-037 SHALL cover: address 5 bit 0 stuck-at-1 -> fail=1, fail_count=3, fail_addr=5, fail_data=0x01.
REQ-038 SHALL cover: address 0 bit 7 stuck-at-0 -> fail_count=2, fail_addr=0, fail_data=0x7F (first fail in M2).
REQ-039 SHALL cover: rst asserted mid-M3, then start -> full fresh run, done after 162 cycles, counters not carried over.
REQ-040 SHALL cover: start re-pulsed during RUN -> ignored; op sequence and done timing identical to the single-start run.
REQ-041 SHALL cover: macro undefined with the stuck-at fault of REQ-037 -> fail=1, fail_count=0, fail_addr=0.
